// File: rtl/dht11_pkg.sv
// Shared DHT11 protocol definitions: FSM states, default timing (us), frame layout.
// Used by both the sensor emulator and the host reader.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_RESP_WAIT,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW
    } dht11_state_e;

    localparam int unsigned DHT11_CLK_DIV      = 50;
    localparam int unsigned DHT11_START_MIN_US = 18000;
    localparam int unsigned DHT11_RESP_WAIT_US = 12;
    localparam int unsigned DHT11_RESP_LOW_US  = 80;
    localparam int unsigned DHT11_RESP_HIGH_US = 80;
    localparam int unsigned DHT11_BIT_LOW_US   = 50;
    localparam int unsigned DHT11_BIT0_HIGH_US = 26;
    localparam int unsigned DHT11_BIT1_HIGH_US = 70;
    localparam int unsigned DHT11_END_LOW_US   = 50;

    localparam int unsigned FRAME_BITS  = 40;
    localparam int unsigned HOST_CNT_W  = 17;
    localparam int unsigned HUM_INT_OFS = 32;
    localparam int unsigned HUM_DEC_OFS = 24;
    localparam int unsigned TMP_INT_OFS = 16;
    localparam int unsigned TMP_DEC_OFS = 8;
    localparam int unsigned CHK_OFS     = 0;

    function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        logic [7:0] s;
        s = a + b + c + d;
        return s;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks.
module us_tick_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 device-side emulator: detects host start pulse, answers with response and
// a 40-bit frame on an open-drain line (dht11_oe=1 pulls low).
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_DIV      = DHT11_CLK_DIV,
    parameter int unsigned START_MIN_US = DHT11_START_MIN_US,
    parameter int unsigned RESP_WAIT_US = DHT11_RESP_WAIT_US,
    parameter int unsigned RESP_LOW_US  = DHT11_RESP_LOW_US,
    parameter int unsigned RESP_HIGH_US = DHT11_RESP_HIGH_US,
    parameter int unsigned BIT_LOW_US   = DHT11_BIT_LOW_US,
    parameter int unsigned BIT0_HIGH_US = DHT11_BIT0_HIGH_US,
    parameter int unsigned BIT1_HIGH_US = DHT11_BIT1_HIGH_US,
    parameter int unsigned END_LOW_US   = DHT11_END_LOW_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht11_in,
    output logic       dht11_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
    input  logic       load,
    input  logic       corrupt_chk,
    output logic       busy,
    output logic       frame_done,
    output logic       err_short_start
);

    logic tick;

    us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Line idles high (pull-up), so the synchronizer resets to 1.
    logic s1, s2, s3;
    logic fell, rose;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= dht11_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fell = s3 & ~s2;
    assign rose = ~s3 & s2;

    logic [7:0] sh_hum_int, sh_hum_dec, sh_tmp_int, sh_tmp_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_hum_int <= '0;
            sh_hum_dec <= '0;
            sh_tmp_int <= '0;
            sh_tmp_dec <= '0;
        end else if (load) begin
            sh_hum_int <= hum_int;
            sh_hum_dec <= hum_dec;
            sh_tmp_int <= tmp_int;
            sh_tmp_dec <= tmp_dec;
        end
    end

    logic [7:0]            chk_raw;
    logic [FRAME_BITS-1:0] frame_snap;

    always_comb begin
        chk_raw    = dht11_checksum(sh_hum_int, sh_hum_dec, sh_tmp_int, sh_tmp_dec);
        frame_snap = '0;
        frame_snap[HUM_INT_OFS +: 8] = sh_hum_int;
        frame_snap[HUM_DEC_OFS +: 8] = sh_hum_dec;
        frame_snap[TMP_INT_OFS +: 8] = sh_tmp_int;
        frame_snap[TMP_DEC_OFS +: 8] = sh_tmp_dec;
        frame_snap[CHK_OFS +: 8]     = corrupt_chk ? ~chk_raw : chk_raw;
    end

    dht11_state_e          state;
    logic [HOST_CNT_W-1:0] dur;
    logic [HOST_CNT_W-1:0] target_m1;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  timed;
    logic                  expired;

    always_comb begin
        target_m1 = '0;
        timed     = 1'b1;
        case (state)
            ST_RESP_WAIT: target_m1 = HOST_CNT_W'(RESP_WAIT_US - 1);
            ST_RESP_LOW:  target_m1 = HOST_CNT_W'(RESP_LOW_US - 1);
            ST_RESP_HIGH: target_m1 = HOST_CNT_W'(RESP_HIGH_US - 1);
            ST_BIT_LOW:   target_m1 = HOST_CNT_W'(BIT_LOW_US - 1);
            ST_BIT_HIGH:  target_m1 = frame[FRAME_BITS-1] ? HOST_CNT_W'(BIT1_HIGH_US - 1)
                                                          : HOST_CNT_W'(BIT0_HIGH_US - 1);
            ST_END_LOW:   target_m1 = HOST_CNT_W'(END_LOW_US - 1);
            default:      timed     = 1'b0;
        endcase
        expired = timed & tick & (dur == target_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            dur             <= '0;
            bit_idx         <= '0;
            frame           <= '0;
            dht11_oe        <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            err_short_start <= 1'b0;
        end else begin
            frame_done      <= 1'b0;
            err_short_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fell) begin
                        state <= ST_HOST_LOW;
                        dur   <= '0;
                    end
                end
                ST_HOST_LOW: begin
                    if (rose) begin
                        dur <= '0;
                        if (dur >= HOST_CNT_W'(START_MIN_US)) begin
                            frame   <= frame_snap;
                            bit_idx <= '0;
                            busy    <= 1'b1;
                            state   <= ST_RESP_WAIT;
                        end else begin
                            err_short_start <= 1'b1;
                            state           <= ST_IDLE;
                        end
                    end else if (tick && dur != '1) begin
                        dur <= dur + 1'b1;
                    end
                end
                ST_RESP_WAIT: if (expired) begin
                    state    <= ST_RESP_LOW;
                    dht11_oe <= 1'b1;
                end
                ST_RESP_LOW: if (expired) begin
                    state    <= ST_RESP_HIGH;
                    dht11_oe <= 1'b0;
                end
                ST_RESP_HIGH: if (expired) begin
                    state    <= ST_BIT_LOW;
                    bit_idx  <= '0;
                    dht11_oe <= 1'b1;
                end
                ST_BIT_LOW: if (expired) begin
                    state    <= ST_BIT_HIGH;
                    dht11_oe <= 1'b0;
                end
                ST_BIT_HIGH: if (expired) begin
                    frame    <= {frame[FRAME_BITS-2:0], 1'b0};
                    bit_idx  <= bit_idx + 1'b1;
                    dht11_oe <= 1'b1;
                    state    <= (bit_idx == 6'(FRAME_BITS - 1)) ? ST_END_LOW : ST_BIT_LOW;
                end
                ST_END_LOW: if (expired) begin
                    state      <= ST_IDLE;
                    dht11_oe   <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
            // Shared duration counter for the timed states; clears on each transition.
            if (timed) begin
                if (expired)
                    dur <= '0;
                else if (tick)
                    dur <= dur + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes and compares.
module tb_dht11_sensor_emu;

    localparam int unsigned D         = 2;
    localparam int unsigned START_MIN = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_low;
    logic       dht11_in;
    logic       dht11_oe;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic       load, corrupt_chk;
    logic       busy, frame_done, err_short_start;

    assign dht11_in = (dht11_oe || host_low) ? 1'b0 : 1'b1;

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CLK_DIV      (D),
        .START_MIN_US (START_MIN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dht11_in        (dht11_in),
        .dht11_oe        (dht11_oe),
        .hum_int         (hum_int),
        .hum_dec         (hum_dec),
        .tmp_int         (tmp_int),
        .tmp_dec         (tmp_dec),
        .load            (load),
        .corrupt_chk     (corrupt_chk),
        .busy            (busy),
        .frame_done      (frame_done),
        .err_short_start (err_short_start)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [39:0] exp_q[$];

    int unsigned cyc = 0;
    int unsigned release_cyc = 0;
    int unsigned pulse_idx = 0;
    int unsigned run = 0;
    int unsigned viol = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt = 0;
    logic [39:0] cap = '0;
    logic        prev_oe = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit in_rng(input int unsigned cycles, input int unsigned n_us);
        return (cycles >= (n_us - 1) * D) && (cycles <= (n_us + 1) * D);
    endfunction

    // Line monitor: measures oe low/released widths, decodes bits, scores on frame_done.
    always @(negedge clk) begin
        logic [39:0] exp;
        cyc++;
        if (rst) begin
            pulse_idx = 0;
            run       = 0;
            viol      = 0;
            cap       = '0;
            prev_oe   = 1'b0;
        end else begin
            if (dht11_oe !== prev_oe) begin
                if (dht11_oe) begin
                    if (pulse_idx == 0) begin
                        if (!((cyc - release_cyc) >= 11 * D && (cyc - release_cyc) <= 12 * D + 6))
                            viol++;
                    end else if (pulse_idx == 1) begin
                        if (!in_rng(run, 80)) viol++;
                    end else begin
                        if (run > 48 * D) begin
                            cap = {cap[38:0], 1'b1};
                            if (!in_rng(run, 70)) viol++;
                        end else begin
                            cap = {cap[38:0], 1'b0};
                            if (!in_rng(run, 26)) viol++;
                        end
                    end
                    pulse_idx++;
                end else begin
                    if (pulse_idx == 1) begin
                        if (!in_rng(run, 80)) viol++;
                    end else begin
                        if (!in_rng(run, 50)) viol++;
                    end
                end
                run = 1;
            end else begin
                run++;
            end
            prev_oe = dht11_oe;
            if (dht11_oe && !busy) viol++;
            if (err_short_start) err_cnt++;
            if (frame_done) begin
                done_cnt++;
                check("frame_pulses", 64'(pulse_idx), 64'd42);
                check("frame_timing", 64'(viol), 64'd0);
                check("busy_clear_at_done", 64'(busy), 64'd0);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame_unexpected: got frame 0x%010h, expected none", cap);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame_data", 64'(cap), 64'(exp));
                end
                pulse_idx = 0;
                viol      = 0;
                cap       = '0;
            end
        end
    end

    task automatic do_load(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        hum_int = a;
        hum_dec = b;
        tmp_int = c;
        tmp_dec = d;
        load    = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic host_start(input int unsigned low_us);
        host_low = 1'b1;
        repeat (low_us * D) @(posedge clk);
        #1 host_low = 1'b0;
        release_cyc = cyc;
    endtask

    task automatic wait_busy(input logic lvl, input int unsigned max_cyc, input string name);
        int unsigned n = 0;
        while (busy !== lvl && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(busy), 64'(lvl));
    endtask

    task automatic wait_pulse(input int unsigned idx, input string name);
        int unsigned n = 0;
        while (!(pulse_idx == idx && dht11_oe) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(pulse_idx), 64'(idx));
    endtask

    task automatic gap(input int unsigned us);
        repeat (us * D) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [39:0] exp, input string name);
        exp_q.push_back(exp);
        host_start(250);
        wait_busy(1'b1, 20, {name, "_busy_accept"});
        wait_busy(1'b0, 20000, {name, "_busy_end"});
        gap(20);
    endtask

    initial begin
        int unsigned e0, d0, seen;
        rst         = 1'b1;
        host_low    = 1'b0;
        load        = 1'b0;
        corrupt_chk = 1'b0;
        hum_int     = '0;
        hum_dec     = '0;
        tmp_int     = '0;
        tmp_dec     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({dht11_oe, busy, frame_done, err_short_start}), 64'd0);
        rst = 1'b0;
        gap(5);

        do_load(8'h37, 8'h00, 8'h18, 8'h05);
        run_frame(40'h37_00_18_05_54, "basic");

        e0   = err_cnt;
        d0   = done_cnt;
        seen = 0;
        host_start(50);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (dht11_oe || busy) seen++;
        end
        check("short_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("short_line_quiet", 64'(seen), 64'd0);
        check("short_no_frame", 64'(done_cnt - d0), 64'd0);

        corrupt_chk = 1'b1;
        exp_q.push_back(40'h37_00_18_05_AB);
        host_start(250);
        wait_busy(1'b1, 20, "corrupt_busy_accept");
        corrupt_chk = 1'b0;
        wait_busy(1'b0, 20000, "corrupt_busy_end");
        gap(20);

        exp_q.push_back(40'h37_00_18_05_54);
        host_start(250);
        wait_busy(1'b1, 20, "midload_busy_accept");
        wait_pulse(7, "midload_reach_bit5");
        do_load(8'h11, 8'h22, 8'h33, 8'h44);
        wait_busy(1'b0, 20000, "midload_busy_end");
        gap(20);
        run_frame(40'h11_22_33_44_AA, "newload");

        d0 = done_cnt;
        host_start(250);
        wait_busy(1'b1, 20, "abort_busy_accept");
        wait_pulse(19, "abort_reach_bit17");
        #1 rst = 1'b1;
        #1;
        check("abort_oe_async", 64'(dht11_oe), 64'd0);
        check("abort_busy_async", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        gap(100);
        check("abort_no_frame_done", 64'(done_cnt - d0), 64'd0);

        run_frame(40'h00_00_00_00_00, "post_reset");

        do_load(8'hFF, 8'hFF, 8'h01, 8'h02);
        run_frame(40'hFF_FF_01_02_01, "chk_wrap");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("frame_done_total", 64'(done_cnt), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
